// File: rtl/multi_injector_sequencer.sv
// multi_injector_sequencer: CYLINDERS-wide crank-synchronous injector bank.
// Optional INJ_OVERLAP_LIMIT_EN caps concurrent pulses at MAX_ACTIVE.
module multi_injector_sequencer #(
  parameter int         CYLINDERS   = 4,
  parameter int         NUM_TEETH   = 60,
  parameter int         PW_WIDTH    = 20,
  parameter logic [1:0] INTAKE_CODE = 2'b00,
  localparam int        TW          = $clog2(NUM_TEETH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    on,
  input  logic [TW-1:0]           crank_counter,
  input  logic                    crank_changed,
  input  logic [2*CYLINDERS-1:0]  stroke,
  input  logic [CYLINDERS-1:0]    allow_injection,
  input  logic [TW*CYLINDERS-1:0] start_tooth,
  input  logic [PW_WIDTH-1:0]     pulse_width,
  input  logic                    pw_valid,
  output logic [CYLINDERS-1:0]    inject,
  output logic [CYLINDERS-1:0]    done,
  output logic [CYLINDERS-1:0]    fault
);

`ifdef INJ_OVERLAP_LIMIT_EN
  localparam int MAX_ACTIVE = 2;
  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_INJECT, S_HOLD, S_PENDING
  } state_t;
  int busy;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_ARMED, S_INJECT, S_HOLD
  } state_t;
`endif

  state_t              state_q [CYLINDERS];
  state_t              state_d [CYLINDERS];
  logic [PW_WIDTH-1:0] pw_q    [CYLINDERS];
  logic [PW_WIDTH-1:0] pw_d    [CYLINDERS];
  logic [PW_WIDTH-1:0] cnt_q   [CYLINDERS];
  logic [PW_WIDTH-1:0] cnt_d   [CYLINDERS];
  logic [PW_WIDTH-1:0] shadow_q;
  logic [CYLINDERS-1:0] match;
  logic [CYLINDERS-1:0] intake;
  logic [CYLINDERS-1:0] inject_d;
  logic [CYLINDERS-1:0] done_d;
  logic [CYLINDERS-1:0] fault_d;

  always_comb begin
    match  = '0;
    intake = '0;
    for (int i = 0; i < CYLINDERS; i++) begin
      match[i]  = crank_changed &&
                  (crank_counter == start_tooth[TW*i +: TW]);
      intake[i] = (stroke[2*i +: 2] == INTAKE_CODE);
    end
  end

  always_comb begin
`ifdef INJ_OVERLAP_LIMIT_EN
    // slots held by pulses that keep running past this edge
    busy = 0;
    for (int i = 0; i < CYLINDERS; i++)
      if (state_q[i] == S_INJECT && cnt_q[i] != PW_WIDTH'(1))
        busy = busy + 1;
`endif
    for (int i = 0; i < CYLINDERS; i++) begin
      state_d[i]  = state_q[i];
      pw_d[i]     = pw_q[i];
      cnt_d[i]    = cnt_q[i];
      done_d[i]   = 1'b0;
      fault_d[i]  = 1'b0;
      if (!on) begin
        state_d[i] = S_IDLE;
        pw_d[i]    = '0;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          S_IDLE: begin
            if (allow_injection[i] && intake[i]) begin
              state_d[i] = S_ARMED;
              pw_d[i]    = pw_valid ? pulse_width : shadow_q;
            end
          end
          S_ARMED: begin
            if (!allow_injection[i]) begin
              state_d[i] = S_IDLE;
              fault_d[i] = 1'b1;
            end else if (match[i]) begin
              if (pw_q[i] == '0) begin
                state_d[i] = S_HOLD;
                done_d[i]  = 1'b1;
`ifdef INJ_OVERLAP_LIMIT_EN
              end else if (busy >= MAX_ACTIVE) begin
                state_d[i] = S_PENDING;
`endif
              end else begin
                state_d[i] = S_INJECT;
                cnt_d[i]   = pw_q[i];
`ifdef INJ_OVERLAP_LIMIT_EN
                busy = busy + 1;
`endif
              end
            end
          end
          S_INJECT: begin
            if (cnt_q[i] <= PW_WIDTH'(1)) begin
              state_d[i] = S_HOLD;
              cnt_d[i]   = '0;
              done_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - PW_WIDTH'(1);
            end
          end
          S_HOLD: begin
            if (!allow_injection[i])
              state_d[i] = S_IDLE;
          end
`ifdef INJ_OVERLAP_LIMIT_EN
          S_PENDING: begin
            if (!allow_injection[i]) begin
              state_d[i] = S_IDLE;
              fault_d[i] = 1'b1;
            end else if (busy < MAX_ACTIVE) begin
              state_d[i] = S_INJECT;
              cnt_d[i]   = pw_q[i];
              busy = busy + 1;
            end
          end
`endif
          default: state_d[i] = S_IDLE;
        endcase
      end
      inject_d[i] = (state_d[i] == S_INJECT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      inject   <= '0;
      done     <= '0;
      fault    <= '0;
      for (int i = 0; i < CYLINDERS; i++) begin
        state_q[i] <= S_IDLE;
        pw_q[i]    <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      if (pw_valid)
        shadow_q <= pulse_width;
      inject <= inject_d;
      done   <= done_d;
      fault  <= fault_d;
      for (int i = 0; i < CYLINDERS; i++) begin
        state_q[i] <= state_d[i];
        pw_q[i]    <= pw_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_injector_sequencer.sv
// tb_multi_injector_sequencer: directed vector table plus randomized
// run against a window/pulse reference model.
module tb_multi_injector_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        on;
  logic [5:0]  crank_counter;
  logic        crank_changed;
  logic [7:0]  stroke;
  logic [3:0]  allow_injection;
  logic [23:0] start_tooth;
  logic [19:0] pulse_width;
  logic        pw_valid;
  logic [3:0]  inject;
  logic [3:0]  done;
  logic [3:0]  fault;

  int tests = 0;
  int fails = 0;

  always #4 clk = ~clk;

  multi_injector_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .on              (on),
    .crank_counter   (crank_counter),
    .crank_changed   (crank_changed),
    .stroke          (stroke),
    .allow_injection (allow_injection),
    .start_tooth     (start_tooth),
    .pulse_width     (pulse_width),
    .pw_valid        (pw_valid),
    .inject          (inject),
    .done            (done),
    .fault           (fault)
  );

  typedef struct {
    bit          rst;
    bit          en;
    logic [3:0]  al;
    logic [7:0]  sk;
    bit          cchg;
    logic [5:0]  cc;
    logic [23:0] st;
    logic [19:0] pw;
    bit          pwl;
    int          n;
    logic [3:0]  ei;
    logic [3:0]  ed;
    logic [3:0]  ef;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [23:0] st_all(int a, int b, int c, int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic add(bit rst, bit en, logic [3:0] al, logic [7:0] sk,
                     bit cchg, int ccv, logic [23:0] st, int pw,
                     bit pwl, int n, logic [3:0] ei, logic [3:0] ed,
                     logic [3:0] ef);
    vec_t v;
    v.rst = rst; v.en = en; v.al = al; v.sk = sk;
    v.cchg = cchg; v.cc = 6'(ccv); v.st = st;
    v.pw = 20'(pw); v.pwl = pwl; v.n = n;
    v.ei = ei; v.ed = ed; v.ef = ef;
    tbl.push_back(v);
  endtask

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  // reference model: window/pulse bookkeeping per channel
  int m_left[4];
  bit m_armed[4];
  bit m_used[4];
  int m_pw[4];
  int m_shadow;

  task automatic model_step(output logic [3:0] ei, output logic [3:0] ed,
                            output logic [3:0] ef);
    ei = '0; ed = '0; ef = '0;
    if (reset) begin
      m_shadow = 0;
      for (int c = 0; c < 4; c++) begin
        m_left[c] = 0; m_armed[c] = 0; m_used[c] = 0; m_pw[c] = 0;
      end
      return;
    end
    for (int c = 0; c < 4; c++) begin
      bit hit;
      hit = crank_changed && (crank_counter == start_tooth[6*c +: 6]);
      if (!on) begin
        m_left[c] = 0; m_armed[c] = 0; m_used[c] = 0;
      end else if (m_left[c] > 0) begin
        m_left[c]--;
        if (m_left[c] > 0) ei[c] = 1'b1;
        else begin ed[c] = 1'b1; m_used[c] = 1; end
      end else if (m_armed[c]) begin
        if (!allow_injection[c]) begin
          m_armed[c] = 0; ef[c] = 1'b1;
        end else if (hit) begin
          m_armed[c] = 0;
          if (m_pw[c] == 0) begin ed[c] = 1'b1; m_used[c] = 1; end
          else begin m_left[c] = m_pw[c]; ei[c] = 1'b1; end
        end
      end else if (m_used[c]) begin
        if (!allow_injection[c]) m_used[c] = 0;
      end else if (allow_injection[c] && stroke[2*c +: 2] == 2'b00) begin
        m_armed[c] = 1;
        m_pw[c] = pw_valid ? int'(pulse_width) : m_shadow;
      end
    end
    if (pw_valid) m_shadow = int'(pulse_width);
  endtask

  initial begin
    logic [23:0] s0, s1;
    logic [3:0]  ei, ed, ef;
    s0 = st_all(5, 40, 10, 10);
    s1 = st_all(10, 10, 10, 10);

    // reset and disabled with toggling inputs
    add(1, 0, 4'hF, 8'h00, 1, 5, s0, 100, 1, 3, 0, 0, 0);
    add(0, 0, 4'hF, 8'h00, 1, 5, s0, 50, 1, 2, 0, 0, 0);
    add(0, 0, 4'h0, 8'hA5, 0, 9, s0, 3, 0, 1, 0, 0, 0);
    add(0, 0, 4'hF, 8'h00, 1, 10, s1, 3, 1, 2, 0, 0, 0);
    // basic 100-cycle pulse on channel 0
    add(0, 1, 4'h0, 8'h00, 0, 0, s0, 100, 1, 1, 0, 0, 0);
    add(0, 1, 4'h1, 8'h00, 0, 0, s0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 4'h1, 8'h00, 1, 5, s0, 0, 0, 1, 4'h1, 0, 0);
    add(0, 1, 4'h1, 8'h00, 0, 5, s0, 0, 0, 99, 4'h1, 0, 0);
    add(0, 1, 4'h1, 8'h00, 0, 5, s0, 0, 0, 1, 0, 4'h1, 0);
    add(0, 1, 4'h1, 8'h00, 1, 5, s0, 0, 0, 3, 0, 0, 0);
    add(0, 1, 4'h0, 8'h00, 0, 5, s0, 0, 0, 1, 0, 0, 0);
    // missed window on channel 1
    add(0, 1, 4'h2, 8'h00, 0, 0, s0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 4'h2, 8'h00, 1, 20, s0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 4'h2, 8'h00, 1, 39, s0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 4'h0, 8'h00, 1, 30, s0, 0, 0, 1, 0, 0, 4'h2);
    add(0, 1, 4'h0, 8'h00, 0, 30, s0, 0, 0, 2, 0, 0, 0);
    // zero width
    add(0, 1, 4'h0, 8'h00, 0, 0, s0, 0, 1, 1, 0, 0, 0);
    add(0, 1, 4'h1, 8'h00, 0, 0, s0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 4'h1, 8'h00, 1, 5, s0, 0, 0, 1, 0, 4'h1, 0);
    add(0, 1, 4'h1, 8'h00, 1, 5, s0, 0, 0, 2, 0, 0, 0);
    add(0, 1, 4'h0, 8'h00, 0, 5, s0, 0, 0, 1, 0, 0, 0);
    // pw_valid in the arming cycle wins over the zero shadow
    add(0, 1, 4'h1, 8'h00, 0, 0, s0, 7, 1, 1, 0, 0, 0);
    add(0, 1, 4'h1, 8'h00, 1, 5, s0, 0, 0, 1, 4'h1, 0, 0);
    add(0, 1, 4'h1, 8'h00, 0, 5, s0, 0, 0, 6, 4'h1, 0, 0);
    add(0, 1, 4'h1, 8'h00, 0, 5, s0, 0, 0, 1, 0, 4'h1, 0);
    add(0, 1, 4'h0, 8'h00, 0, 5, s0, 0, 0, 1, 0, 0, 0);
    // abort mid-pulse with on=0
    add(0, 1, 4'h0, 8'h00, 0, 0, s0, 100, 1, 1, 0, 0, 0);
    add(0, 1, 4'h1, 8'h00, 0, 0, s0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 4'h1, 8'h00, 1, 5, s0, 0, 0, 1, 4'h1, 0, 0);
    add(0, 1, 4'h1, 8'h00, 0, 5, s0, 0, 0, 49, 4'h1, 0, 0);
    add(0, 0, 4'h1, 8'h00, 0, 5, s0, 0, 0, 3, 0, 0, 0);
    add(0, 1, 4'h0, 8'h00, 0, 5, s0, 0, 0, 60, 0, 0, 0);
    // all four channels matching tooth 10
    add(0, 1, 4'h0, 8'h00, 0, 0, s1, 20, 1, 1, 0, 0, 0);
    add(0, 1, 4'hF, 8'h00, 0, 0, s1, 0, 0, 1, 0, 0, 0);
`ifdef INJ_OVERLAP_LIMIT_EN
    add(0, 1, 4'hF, 8'h00, 1, 10, s1, 0, 0, 1, 4'h3, 0, 0);
    add(0, 1, 4'hF, 8'h00, 0, 10, s1, 0, 0, 19, 4'h3, 0, 0);
    add(0, 1, 4'hF, 8'h00, 0, 10, s1, 0, 0, 1, 4'hC, 4'h3, 0);
    add(0, 1, 4'hF, 8'h00, 0, 10, s1, 0, 0, 19, 4'hC, 0, 0);
    add(0, 1, 4'hF, 8'h00, 0, 10, s1, 0, 0, 1, 0, 4'hC, 0);
`else
    add(0, 1, 4'hF, 8'h00, 1, 10, s1, 0, 0, 1, 4'hF, 0, 0);
    add(0, 1, 4'hF, 8'h00, 0, 10, s1, 0, 0, 19, 4'hF, 0, 0);
    add(0, 1, 4'hF, 8'h00, 0, 10, s1, 0, 0, 1, 0, 4'hF, 0);
`endif
    add(0, 1, 4'hF, 8'h00, 0, 10, s1, 0, 0, 2, 0, 0, 0);
    add(0, 1, 4'h0, 8'h00, 0, 10, s1, 0, 0, 1, 0, 0, 0);

    foreach (tbl[k]) begin
      reset           = tbl[k].rst;
      on              = tbl[k].en;
      allow_injection = tbl[k].al;
      stroke          = tbl[k].sk;
      crank_changed   = tbl[k].cchg;
      crank_counter   = tbl[k].cc;
      start_tooth     = tbl[k].st;
      pulse_width     = tbl[k].pw;
      pw_valid        = tbl[k].pwl;
      for (int r = 0; r < tbl[k].n; r++) begin
        @(posedge clk);
        #1;
        chk($sformatf("row%0d.inject", k), inject, tbl[k].ei);
        chk($sformatf("row%0d.done", k), done, tbl[k].ed);
        chk($sformatf("row%0d.fault", k), fault, tbl[k].ef);
      end
    end

`ifndef INJ_OVERLAP_LIMIT_EN
    // randomized run against the reference model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset = (cyc == 0) || ($urandom_range(0, 199) == 0);
      on    = ($urandom_range(0, 49) != 0);
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 15) == 0)
          allow_injection[c] = ~allow_injection[c];
        stroke[2*c +: 2] = ($urandom_range(0, 1) == 0) ?
                           2'b00 : 2'($urandom_range(1, 3));
        if ($urandom_range(0, 31) == 0)
          start_tooth[6*c +: 6] = 6'($urandom_range(0, 7));
      end
      crank_changed = ($urandom_range(0, 1) == 1);
      crank_counter = 6'($urandom_range(0, 7));
      pulse_width   = 20'($urandom_range(0, 12));
      pw_valid      = ($urandom_range(0, 7) == 0);
      model_step(ei, ed, ef);
      @(posedge clk);
      #1;
      chk("rand.inject", inject, ei);
      chk("rand.done", done, ed);
      chk("rand.fault", fault, ef);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_injector_sequencer.md
Name: multi_injector_sequencer

Overview:
- Parametrised successor to the per-cylinder fuel injection controller.
- Drives a CYLINDERS-wide injector bank from crank position:
  - arms each channel on its injection window;
  - starts the pulse at a programmable start tooth;
  - times the pulse width in clock cycles;
  - reports done/fault per channel.
- Sits between stroke_transition/crank_position_control and the injector drivers.
- Replaces N separate fuel_injection_control instances.

Parameters:
- CYLINDERS, 4, number of injector channels.
- NUM_TEETH, 60, crank teeth per revolution; tooth index width TW = $clog2(NUM_TEETH).
- PW_WIDTH, 20, pulse-width counter width (max 2^PW_WIDTH-1 clocks, ~8.4 ms at 125 MHz).
- INTAKE_CODE, 2'b00, stroke encoding on which injection is permitted.

Ports:
- clk  in  1  system clock, 125 MHz.
- reset  in  1  synchronous reset, active-high.
- on  in  1  global enable; 0 forces all channels idle.
- crank_counter  in  TW  current tooth index.
- crank_changed  in  1  one-cycle strobe: crank_counter updated this cycle.
- stroke  in  2*CYLINDERS  per-channel stroke code; channel i at bits [2i+1:2i].
- allow_injection  in  CYLINDERS  per-channel injection window.
- start_tooth  in  TW*CYLINDERS  per-channel start tooth; channel i at bits [TW*i+TW-1:TW*i].
- pulse_width  in  PW_WIDTH  requested pulse width in clocks.
- pw_valid  in  1  load pulse_width into the shadow register.
- inject  out  CYLINDERS  injector drive, registered.
- done  out  CYLINDERS  one-cycle pulse when a channel's injection completes.
- fault  out  CYLINDERS  one-cycle pulse when a window closes before the start tooth.

Behaviour:
- Reset: all outputs 0, all channels IDLE, pw shadow register = 0, counters = 0.
- Shadow register: loads pulse_width on any cycle with pw_valid=1; otherwise holds.
- Per-channel FSM states: IDLE, ARMED, INJECT, HOLD.
- IDLE -> ARMED when on && allow_injection[i] && stroke[i]==INTAKE_CODE.
  - The channel latches the shadow value into its private pw_i in that cycle.
  - If pw_valid is high in the same cycle, the new pulse_width is used.
- ARMED -> INJECT on a cycle with crank_changed && crank_counter==start_tooth[i].
  - Counter loads pw_i; inject[i]=1 from the next cycle.
- ARMED with pw_i==0 on a start match -> HOLD; done[i] pulses next cycle; inject stays 0.
- ARMED with allow_injection[i] falling before a match -> IDLE; fault[i]=1 for one cycle.
- INJECT: counter decrements every clk.
  - inject[i] is high for exactly pw_i cycles.
  - done[i]=1 in the first cycle inject[i] is low again; then HOLD.
- INJECT is not truncated by allow_injection falling; the pulse completes.
- HOLD -> IDLE once allow_injection[i]==0, so there is at most one injection per window.
- start_tooth[i] changes while ARMED take effect on the next compare.
- A start tooth missed because crank_changed never coincided keeps the channel ARMED until the window closes (then fault).
- on=0 in any state:
  - next cycle all channels IDLE, inject=0;
  - no done or fault pulses;
  - counters cleared.
- reset mid-pulse: same as on=0, plus the shadow register is cleared.
- Channels are independent; simultaneous matches on several channels all start in the same cycle.

Optional Feature:
- Macro INJ_OVERLAP_LIMIT_EN.
- Defined: localparam MAX_ACTIVE (default 2) caps the number of channels with inject high at once.
  - A channel matching its start tooth while the cap is reached becomes PENDING.
  - PENDING starts INJECT in the first cycle a slot frees.
  - Simultaneous requests are granted lowest index first.
  - PENDING with the window closing -> IDLE with fault[i].
- Undefined: no PENDING state, no arbitration; behaviour exactly as above.

Test Plan:
- Reset/idle: reset=1 for 3 clks, then on=0 with stimulus toggling -> inject, done and fault stay 0.
- Basic pulse, channel 0:
  - stimulus: pulse_width=100 with pw_valid, allow_injection[0]=1, stroke[0]=00, start_tooth[0]=5, crank_changed with crank_counter=5;
  - response: inject[0] high 100 cycles starting 1 clk after the match, done[0] pulses in cycle 101, then HOLD until window drop.
- Missed window: channel 1 armed with start_tooth=40; window drops at tooth 30 -> fault[1] one cycle, no inject.
- Zero width and same-cycle load:
  - pw shadow 0 -> match gives done with no inject;
  - pw_valid high in the arming cycle with pulse_width=7 -> pulse of 7 cycles.
- Abort: on=0 at cycle 50 of a 100-cycle pulse -> inject 0 next cycle, no done; with all channels armed on tooth 10, every channel injects concurrently.
- With INJ_OVERLAP_LIMIT_EN, MAX_ACTIVE=2, 4 channels matching tooth 10 with pw=20:
  - channels 0 and 1 inject at +1;
  - channels 2 and 3 start at +21;
  - each sees done exactly once.
